// File: rtl/pila_retorno.sv
// Return-address stack: push stores the return PC, pop exposes the top entry
// combinationally so the PC mux can load it in the same cycle.
module pila_retorno #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           d_in,
  output logic [WIDTH-1:0]           d_out,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty,
  output logic                       full,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [CW-1:0]    r_count;
  logic             r_overflow;
  logic             r_underflow;

  logic [CW-1:0]    w_count_m1;
  logic [AW-1:0]    w_top_idx;
  logic [AW-1:0]    w_wr_idx;
  logic             w_empty;
  logic             w_full;
  logic             w_do_push;
  logic             w_do_replace;
  logic             w_do_pop;
  logic             w_set_ovf;
  logic             w_set_unf;

  // push/pop are single-cycle strobes with no handshake: each is consumed at
  // the rising edge it is high; a rejected operation only raises a sticky flag.
  assign w_count_m1 = r_count - CW'(1);
  assign w_top_idx  = w_count_m1[AW-1:0];
  assign w_wr_idx   = r_count[AW-1:0];
  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == CW'(DEPTH));

  // Push+pop on an empty stack degenerates to a plain push.
  assign w_do_push    = push && !w_full && (!pop || w_empty);
  assign w_do_replace = push && pop && !w_empty;
  assign w_do_pop     = pop && !push && !w_empty;
  assign w_set_ovf    = push && !pop && w_full;
  assign w_set_unf    = pop && !push && w_empty;

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[w_wr_idx] <= d_in;
    end else if (w_do_replace) begin
      r_mem[w_top_idx] <= d_in;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_do_push) begin
        r_count <= r_count + CW'(1);
      end else if (w_do_pop) begin
        r_count <= w_count_m1;
      end
      if (w_set_ovf) begin
        r_overflow <= 1'b1;
      end
      if (w_set_unf) begin
        r_underflow <= 1'b1;
      end
    end
  end

  assign d_out     = w_empty ? '0 : r_mem[w_top_idx];
  assign count     = r_count;
  assign empty     = w_empty;
  assign full      = w_full;
  assign overflow  = r_overflow;
  assign underflow = r_underflow;

endmodule

// File: tb/tb_pila_retorno.sv
// Directed bench for pila_retorno: one task per scenario, inline checks.
module tb_pila_retorno;

  logic       clk;
  logic       reset;
  logic       push;
  logic       pop;
  logic [9:0] d_in;
  logic [9:0] d_out;
  logic [3:0] count;
  logic       empty;
  logic       full;
  logic       overflow;
  logic       underflow;

  int checks = 0;
  int errors = 0;

  pila_retorno #(.WIDTH(10), .DEPTH(8)) dut (
    .clk(clk), .reset(reset), .push(push), .pop(pop), .d_in(d_in),
    .d_out(d_out), .count(count), .empty(empty), .full(full),
    .overflow(overflow), .underflow(underflow)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // driver tasks
  task automatic cycle(input logic p, input logic q, input logic [9:0] d);
    push = p; pop = q; d_in = d;
    @(posedge clk); #1;
    push = 1'b0; pop = 1'b0;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; push = 1'b1; pop = 1'b0; d_in = 10'h155;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      checks++;
      if (count !== 4'd0 || empty !== 1'b1 || d_out !== 10'h000 ||
          overflow !== 1'b0 || underflow !== 1'b0) begin
        errors++;
        $display("FAIL reset_state actual=cnt%0d e%0b d%h o%0b u%0b expected=cnt0 e1 d000 o0 u0",
                 count, empty, d_out, overflow, underflow);
      end
    end
    push = 1'b0;
    reset = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (count !== 4'd0 || d_out !== 10'h000) begin
      errors++;
      $display("FAIL reset_no_write actual=cnt%0d d%h expected=cnt0 d000", count, d_out);
    end
  endtask

  task automatic test_lifo();
    logic [9:0] vals [3];
    vals[0] = 10'h005; vals[1] = 10'h012; vals[2] = 10'h3FF;
    apply_reset();
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, vals[i]);
    checks++;
    if (count !== 4'd3 || d_out !== 10'h3FF) begin
      errors++;
      $display("FAIL lifo_fill actual=cnt%0d d%h expected=cnt3 d3ff", count, d_out);
    end
    for (int i = 2; i >= 0; i--) begin
      checks++;
      if (d_out !== vals[i]) begin
        errors++;
        $display("FAIL lifo_pop%0d actual=%h expected=%h", i, d_out, vals[i]);
      end
      cycle(1'b0, 1'b1, 10'h000);
    end
    checks++;
    if (count !== 4'd0 || empty !== 1'b1) begin
      errors++;
      $display("FAIL lifo_drain actual=cnt%0d e%0b expected=cnt0 e1", count, empty);
    end
  endtask

  task automatic test_full_overflow();
    apply_reset();
    for (int i = 1; i <= 8; i++) cycle(1'b1, 1'b0, 10'(i));
    checks++;
    if (full !== 1'b1 || count !== 4'd8 || d_out !== 10'd8 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL full_state actual=f%0b cnt%0d d%h o%0b expected=f1 cnt8 d008 o0",
               full, count, d_out, overflow);
    end
    cycle(1'b1, 1'b0, 10'h0AA);
    checks++;
    if (count !== 4'd8 || d_out !== 10'd8 || overflow !== 1'b1 || full !== 1'b1) begin
      errors++;
      $display("FAIL overflow_state actual=cnt%0d d%h o%0b f%0b expected=cnt8 d008 o1 f1",
               count, d_out, overflow, full);
    end
    for (int i = 8; i >= 1; i--) begin
      checks++;
      if (d_out !== 10'(i)) begin
        errors++;
        $display("FAIL overflow_pop%0d actual=%h expected=%h", i, d_out, 10'(i));
      end
      cycle(1'b0, 1'b1, 10'h000);
    end
    checks++;
    if (empty !== 1'b1 || overflow !== 1'b1 || underflow !== 1'b0) begin
      errors++;
      $display("FAIL overflow_drain actual=e%0b o%0b u%0b expected=e1 o1 u0",
               empty, overflow, underflow);
    end
  endtask

  task automatic test_underflow();
    apply_reset();
    cycle(1'b0, 1'b1, 10'h000);
    checks++;
    if (count !== 4'd0 || d_out !== 10'h000 || underflow !== 1'b1) begin
      errors++;
      $display("FAIL underflow_state actual=cnt%0d d%h u%0b expected=cnt0 d000 u1",
               count, d_out, underflow);
    end
    cycle(1'b1, 1'b0, 10'h021);
    checks++;
    if (count !== 4'd1 || d_out !== 10'h021 || underflow !== 1'b1) begin
      errors++;
      $display("FAIL underflow_sticky actual=cnt%0d d%h u%0b expected=cnt1 d021 u1",
               count, d_out, underflow);
    end
  endtask

  task automatic test_push_pop();
    apply_reset();
    cycle(1'b1, 1'b0, 10'h010);
    cycle(1'b1, 1'b0, 10'h020);
    push = 1'b1; pop = 1'b1; d_in = 10'h030;
    #1;
    checks++;
    if (d_out !== 10'h020) begin
      errors++;
      $display("FAIL replace_old_top actual=%h expected=020", d_out);
    end
    @(posedge clk); #1;
    push = 1'b0; pop = 1'b0;
    checks++;
    if (count !== 4'd2 || d_out !== 10'h030 || overflow !== 1'b0 || underflow !== 1'b0) begin
      errors++;
      $display("FAIL replace_top actual=cnt%0d d%h o%0b u%0b expected=cnt2 d030 o0 u0",
               count, d_out, overflow, underflow);
    end
    cycle(1'b0, 1'b1, 10'h000);
    checks++;
    if (count !== 4'd1 || d_out !== 10'h010) begin
      errors++;
      $display("FAIL replace_below actual=cnt%0d d%h expected=cnt1 d010", count, d_out);
    end
    apply_reset();
    cycle(1'b1, 1'b1, 10'h044);
    checks++;
    if (count !== 4'd1 || d_out !== 10'h044 || underflow !== 1'b0) begin
      errors++;
      $display("FAIL pushpop_empty actual=cnt%0d d%h u%0b expected=cnt1 d044 u0",
               count, d_out, underflow);
    end
    // push+pop while full: replace, no overflow
    for (int i = 0; i < 7; i++) cycle(1'b1, 1'b0, 10'(10'h100 + i));
    cycle(1'b1, 1'b1, 10'h2BC);
    checks++;
    if (count !== 4'd8 || d_out !== 10'h2BC || overflow !== 1'b0) begin
      errors++;
      $display("FAIL pushpop_full actual=cnt%0d d%h o%0b expected=cnt8 d2bc o0",
               count, d_out, overflow);
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    cycle(1'b0, 1'b1, 10'h000);
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 10'(10'h0F0 + i));
    checks++;
    if (count !== 4'd5 || underflow !== 1'b1 || d_out !== 10'h0F4) begin
      errors++;
      $display("FAIL async_pre actual=cnt%0d u%0b d%h expected=cnt5 u1 d0f4",
               count, underflow, d_out);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (count !== 4'd0 || empty !== 1'b1 || d_out !== 10'h000 ||
        overflow !== 1'b0 || underflow !== 1'b0 || clk !== 1'b1) begin
      errors++;
      $display("FAIL async_reset actual=cnt%0d e%0b d%h o%0b u%0b expected=cnt0 e1 d000 o0 u0 before edge",
               count, empty, d_out, overflow, underflow);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    cycle(1'b1, 1'b0, 10'h001);
    checks++;
    if (count !== 4'd1 || d_out !== 10'h001) begin
      errors++;
      $display("FAIL async_after actual=cnt%0d d%h expected=cnt1 d001", count, d_out);
    end
  endtask

  initial begin
    reset = 1'b1; push = 1'b0; pop = 1'b0; d_in = '0;
    #1;
    test_reset();
    test_lifo();
    test_full_overflow();
    test_underflow();
    test_push_pop();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pila_retorno.md
Name: pila_retorno

Overview:
- Return-address stack for the CPU datapath.
- It is the responder to the control unit's push, pop and s_pila strobes.
- On push it stores the incoming return PC. On pop it presents the top entry so the PC mux (s_pila=1) can load it in the same cycle.
- It tracks occupancy and latches sticky overflow/underflow error flags for debug.

Parameters:
WIDTH, 10, bit width of a stored address (PC width).
DEPTH, 8, number of entries; power of two, minimum 2.

Ports:
clk  input  1  system clock, rising-edge active.
reset  input  1  asynchronous, active-high reset.
push  input  1  store d_in on top of stack at this rising edge.
pop  input  1  remove top entry at this rising edge.
d_in  input  WIDTH  return address to push (PC+1 from datapath).
d_out  output  WIDTH  current top-of-stack entry, combinational.
count  output  $clog2(DEPTH+1)  number of valid entries.
empty  output  1  count == 0.
full  output  1  count == DEPTH.
overflow  output  1  sticky: a push was rejected because the stack was full.
underflow  output  1  sticky: a pop was rejected because the stack was empty.

Behaviour:
- One clock: clk. Reset is asynchronous and active-high, on port reset.
- Reset values:
  - count=0, empty=1, full=0, overflow=0, underflow=0, d_out=0.
  - Storage contents need not be cleared.
- Storage: DEPTH x WIDTH register array. Internal stack pointer sp = count; the top entry is index sp-1.
- d_out:
  - Combinational: mem[sp-1] when count>0, else 0.
  - No read latency, so pop and PC load complete in the same cycle.
- Push only (push=1, pop=0):
  - Not full: mem[sp] <= d_in; count += 1. d_out shows d_in from the next cycle.
  - Full: no write; count unchanged; overflow <= 1.
- Pop only (push=0, pop=1):
  - Not empty: count -= 1. d_out before the edge is the popped value.
  - Empty: count unchanged; underflow <= 1; d_out stays 0.
- Push and pop in the same cycle:
  - Not empty: replace top. mem[sp-1] <= d_in; count unchanged. The old top is on d_out during that cycle. No flag change, even when full.
  - Empty: treated as push only. mem[0] <= d_in; count=1; underflow not set.
- Neither push nor pop: no state change.
- Flags:
  - full and empty are combinational decodes of count.
  - overflow and underflow stay set until reset; there is no other clear.
- Count arithmetic: count never exceeds DEPTH and never wraps below 0. Rejected operations leave the contents bit-exact.
- Reset mid-operation: reset wins over any push/pop in the same cycle. The stack is empty immediately (asynchronously) and the flags clear.
- Unknown or X on push/pop is not defined behaviour. The control unit guarantees push/pop are 0 for every non-stack opcode.

Test Plan:
1. Reset: assert reset for 2 cycles with push=1 held -> count=0, empty=1, d_out=0, overflow=0, underflow=0 throughout. No entry is written.
2. LIFO order: push 0x005, 0x012, 0x3FF on consecutive cycles -> count=3, d_out=0x3FF. Then three pops -> d_out reads 0x3FF, 0x012, 0x005 before each edge; ends with count=0, empty=1.
3. Full/overflow: push 1..8 (DEPTH=8) -> full=1, count=8, d_out=8. Ninth push of 0x0AA -> count=8, d_out=8, overflow=1. Then pop 8 times -> sequence 8..1 intact.
4. Underflow: from reset, pop once -> count=0, d_out=0, underflow=1. Push 0x021 -> count=1, d_out=0x021, underflow still 1.
5. Simultaneous push+pop:
   - With stack holding 0x010 and 0x020, push+pop with d_in=0x030 -> count=2, d_out=0x030; next pop exposes 0x010.
   - From empty, push+pop with d_in=0x044 -> count=1, d_out=0x044, underflow=0.
6. Async reset mid-stream: with count=5, raise reset between clock edges -> count=0, empty=1, flags=0 before the next clk edge. After release, push 0x001 -> count=1, d_out=0x001.
